// File: rtl/vector_fb_pkg.sv
// Shared types and constants for the vector framebuffer write path.
// The framebuffer is addressed linearly as row + column*FB_WIDTH.
package vector_fb_pkg;

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    localparam int LANES     = 8;
    localparam int LANE_W    = 32;
    localparam int FB_WIDTH  = 200;
    localparam int FB_PIXELS = 40000;

    localparam int LANE_IDX_W = $clog2(LANES);
    localparam int LANE_SH    = $clog2(LANE_W);

    function automatic logic [LANE_W-1:0] laneOf(
        input logic [LANES*LANE_W-1:0] vec,
        input logic [LANE_IDX_W-1:0]   idx
    );
        return vec[{idx, {LANE_SH{1'b0}}} +: LANE_W];
    endfunction

endpackage

// File: rtl/vector_fb_writer.sv
// Serializes 256-bit vector stores into per-lane framebuffer pixel writes,
// sharing the write port with the scalar path through fb_gnt.
module vector_fb_writer
    import vector_fb_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int LANE_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int FB_PIXELS = 40000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [ADDR_W-1:0]       s_addr,
    input  logic [LANES*LANE_W-1:0] s_data,
    input  logic [LANES-1:0]        s_mask,
    input  logic                    fb_gnt,
    output logic                    fb_we,
    output logic [ADDR_W-1:0]       fb_addr,
    output logic [LANE_W-1:0]       fb_wdata,
    output logic                    busy,
    output logic [15:0]             oob_count
);

    localparam int LW = $clog2(LANES);
    localparam logic [LW-1:0] LAST = LW'(LANES - 1);
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(FB_PIXELS);

    state_t                  state;
    logic [LW-1:0]           lane;
    logic [ADDR_W-1:0]       baseQ;
    logic [LANES*LANE_W-1:0] dataQ;
    logic [LANES-1:0]        maskQ;

    logic [ADDR_W:0] laneAddr;
    logic            inBounds;
    logic            laneOn;
    logic            lastLane;
    logic            accept;

    // One extra address bit so lanes past the top of the index space
    // land out of bounds instead of wrapping onto pixel 0.
    assign laneAddr = {1'b0, baseQ} + (ADDR_W+1)'(lane);
    assign inBounds = laneAddr < LIMIT;
    assign laneOn   = maskQ[lane];
    assign lastLane = lane == LAST;

    assign busy     = state == WRITE;
    assign s_ready  = (state == IDLE) || (fb_gnt && lastLane);
    assign accept   = s_valid && s_ready;

    assign fb_we    = busy && fb_gnt && laneOn && inBounds;
    assign fb_addr  = laneAddr[ADDR_W-1:0];
    assign fb_wdata = laneOf(dataQ, lane);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            lane      <= '0;
            baseQ     <= '0;
            dataQ     <= '0;
            maskQ     <= '0;
            oob_count <= '0;
        end else begin
            if (accept) begin
                baseQ <= s_addr;
                dataQ <= s_data;
                maskQ <= s_mask;
            end
            unique case (state)
                IDLE: begin
                    lane <= '0;
                    if (s_valid) state <= WRITE;
                end
                WRITE: begin
                    if (fb_gnt) begin
                        if (laneOn && !inBounds && oob_count != 16'hFFFF)
                            oob_count <= oob_count + 16'd1;
                        lane <= lastLane ? '0 : lane + 1'b1;
                        if (lastLane && !s_valid) state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_fb_writer.sv
// Directed bench for vector_fb_writer with a write scoreboard.
// Expected pixel writes are queued at request time and matched on fb_we.
module tb_vector_fb_writer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [15:0]  s_addr = '0;
    logic [255:0] s_data = '0;
    logic [7:0]   s_mask = '0;
    logic         fb_gnt = 1'b1;
    logic         fb_we;
    logic [15:0]  fb_addr;
    logic [31:0]  fb_wdata;
    logic         busy;
    logic [15:0]  oob_count;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    logic [15:0] expOob = '0;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t sbq[$];

    always #5 clk = ~clk;

    vector_fb_writer dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_addr   (s_addr),
        .s_data   (s_data),
        .s_mask   (s_mask),
        .fb_gnt   (fb_gnt),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_wdata (fb_wdata),
        .busy     (busy),
        .oob_count(oob_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic present(input logic [15:0] a, input logic [255:0] d,
                           input logic [7:0] m, input int nLanes);
        logic [16:0] la;
        s_valid = 1'b1;
        s_addr  = a;
        s_data  = d;
        s_mask  = m;
        for (int i = 0; i < nLanes; i++) begin
            la = {1'b0, a} + 17'(i);
            if (m[i]) begin
                if (la < 17'd40000)
                    sbq.push_back({la[15:0], d[i*32 +: 32]});
                else if (expOob != 16'hFFFF)
                    expOob++;
            end
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (reset && fb_we) begin
            writes++;
            if (sbq.size() == 0) begin
                chk("spurious_we", 32'(fb_we), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", 32'(fb_addr), 32'(e.addr));
                chk("wr_data", fb_wdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [255:0] d;
        logic [255:0] d2;
        int w0;

        repeat (2) step();
        sample();
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_we", 32'(fb_we), 32'd0);
        chk("rst_addr", 32'(fb_addr), 32'd0);
        chk("rst_wdata", fb_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_oob", 32'(oob_count), 32'd0);
        step();
        reset = 1'b1;

        // basic full-mask store
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = 32'(i * 17);
        step();
        present(16'd100, d, 8'hFF, 8);
        w0 = writes;
        sample();
        chk("accept_ready", 32'(s_ready), 32'd1);
        chk("accept_no_we", 32'(fb_we), 32'd0);
        step();
        s_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sample();
            chk("basic_ready", 32'(s_ready), 32'(k == 7));
            chk("basic_busy", 32'(busy), 32'd1);
            step();
        end
        chk("basic_idle", 32'(busy), 32'd0);
        chk("basic_writes", 32'(writes - w0), 32'd8);
        chk("basic_sb_empty", 32'(sbq.size()), 32'd0);

        // sparse mask then back-to-back request during last lane
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        for (int i = 0; i < 8; i++) d2[i*32 +: 32] = $urandom;
        present(16'd200, d, 8'hA5, 8);
        w0 = writes;
        step();
        s_valid = 1'b0;
        repeat (7) step();
        present(16'd500, d2, 8'hFF, 8);
        sample();
        chk("b2b_ready_last", 32'(s_ready), 32'd1);
        chk("b2b_lane7_we", 32'(fb_we), 32'd1);
        chk("b2b_lane7_addr", 32'(fb_addr), 32'd207);
        step();
        s_valid = 1'b0;
        chk("mask_writes", 32'(writes - w0), 32'd4);
        w0 = writes;
        sample();
        chk("b2b_lane0_we", 32'(fb_we), 32'd1);
        chk("b2b_lane0_addr", 32'(fb_addr), 32'd500);
        chk("b2b_busy", 32'(busy), 32'd1);
        repeat (8) step();
        chk("b2b_writes", 32'(writes - w0), 32'd8);
        chk("b2b_sb_empty", 32'(sbq.size()), 32'd0);
        chk("b2b_idle", 32'(busy), 32'd0);

        // upper bound of framebuffer
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        present(16'd39996, d, 8'hFF, 8);
        w0 = writes;
        step();
        s_valid = 1'b0;
        repeat (8) step();
        chk("bound_writes", 32'(writes - w0), 32'd4);
        chk("bound_oob", 32'(oob_count), 32'(expOob));
        chk("bound_sb_empty", 32'(sbq.size()), 32'd0);

        // top of index space must not wrap to pixel 0
        present(16'hFFFC, d, 8'hFF, 8);
        w0 = writes;
        step();
        s_valid = 1'b0;
        repeat (8) step();
        chk("wrap_writes", 32'(writes - w0), 32'd0);
        chk("wrap_oob", 32'(oob_count), 32'(expOob));

        // fully masked store
        present(16'd600, d, 8'h00, 8);
        w0 = writes;
        step();
        s_valid = 1'b0;
        sample();
        chk("nomask_busy", 32'(busy), 32'd1);
        repeat (8) step();
        chk("nomask_writes", 32'(writes - w0), 32'd0);
        chk("nomask_idle", 32'(busy), 32'd0);

        // grant stall at lane 3
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        present(16'd300, d, 8'hFF, 8);
        w0 = writes;
        step();
        s_valid = 1'b0;
        repeat (3) step();
        fb_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("stall_we", 32'(fb_we), 32'd0);
            chk("stall_ready", 32'(s_ready), 32'd0);
            chk("stall_addr", 32'(fb_addr), 32'd303);
            step();
        end
        fb_gnt = 1'b1;
        sample();
        chk("resume_we", 32'(fb_we), 32'd1);
        chk("resume_addr", 32'(fb_addr), 32'd303);
        repeat (5) step();
        chk("stall_writes", 32'(writes - w0), 32'd8);
        chk("stall_sb_empty", 32'(sbq.size()), 32'd0);

        // reset in the middle of lane 4
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        present(16'd400, d, 8'hFF, 4);
        w0 = writes;
        step();
        s_valid = 1'b0;
        repeat (4) step();
        reset = 1'b0;
        expOob = '0;
        #1;
        chk("midrst_we", 32'(fb_we), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_oob", 32'(oob_count), 32'd0);
        chk("midrst_ready", 32'(s_ready), 32'd1);
        repeat (3) step();
        reset = 1'b1;
        repeat (10) step();
        chk("midrst_writes", 32'(writes - w0), 32'd4);
        chk("midrst_sb_empty", 32'(sbq.size()), 32'd0);
        chk("midrst_idle", 32'(busy), 32'd0);
        chk("midrst_oob_after", 32'(oob_count), 32'(expOob));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_fb_writer.md
Name: vector_fb_writer

Overview:
- Write-side counterpart to the VGA pixel read path: accepts 256-bit vector stores from the vector pipeline's memory stage and serializes them into 32-bit pixel writes on the framebuffer write port.
- The VGA side reads pixels by linear index (row + column*200).
- This block produces writes at the same linear indices, one lane per granted cycle, with per-lane masking and bounds checking.
- Sits between the vector memory stage and the framebuffer RAM write port, sharing that port with the scalar memory stage through a grant input.

Parameters:
- LANES, 8, number of 32-bit lanes per vector store.
- LANE_W, 32, lane/pixel word width; pixel format is {8'h0, B[23:16], G[15:8], R[7:0]}.
- ADDR_W, 16, framebuffer pixel-index width.
- FB_PIXELS, 40000, number of valid pixel indices; index >= FB_PIXELS is out of bounds.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- s_valid  in  1  vector store request valid.
- s_ready  out  1  request accepted on a cycle where s_valid && s_ready.
- s_addr  in  ADDR_W  pixel index of lane 0.
- s_data  in  LANES*LANE_W  lane i occupies bits [32i+31:32i].
- s_mask  in  LANES  lane i written only if s_mask[i]=1.
- fb_gnt  in  1  framebuffer write port granted this cycle (scalar path has priority when low).
- fb_we  out  1  write strobe.
- fb_addr  out  ADDR_W  pixel index.
- fb_wdata  out  LANE_W  pixel word.
- busy  out  1  a request is held (state != IDLE).
- oob_count  out  16  saturating count of lanes dropped for out-of-bounds.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, lane counter=0, holding registers cleared.
  - s_ready=1, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, oob_count=0.
- States: IDLE and WRITE.
- IDLE:
  - s_ready=1.
  - On s_valid: latch s_addr, s_data and s_mask; lane=0; go to WRITE.
  - No fb_we in the accept cycle.
- WRITE:
  - Current lane i = lane counter; lane address = {1'b0,base} + i, computed in ADDR_W+1 bits (no wrap-around).
  - In-bounds means lane address < FB_PIXELS.
  - When fb_gnt=0: hold all state, fb_we=0, s_ready=0.
  - When fb_gnt=1:
    - fb_we = s_mask[i] && in-bounds.
    - fb_addr = lane address[ADDR_W-1:0].
    - fb_wdata = lane i data.
    - If s_mask[i]=1 and out of bounds, increment oob_count, saturating at 16'hFFFF.
    - Advance lane.
  - Outputs fb_we, fb_addr and fb_wdata are combinational from registered state and fb_gnt. fb_addr and fb_wdata always reflect the current lane; only fb_we is gated.
- Last lane (i = LANES-1, granted):
  - s_ready=1 in this cycle.
  - If s_valid, latch the new request and stay in WRITE with lane=0 (back-to-back, no bubble).
  - Otherwise return to IDLE.
- s_ready is 0 in all other WRITE cycles.
- Masked lanes still consume one granted cycle each; no skipping.
- Latency: request accepted at cycle N → lane 0 write at N+1 at the earliest; full store takes LANES granted cycles.
- Fully masked request (s_mask=0): traverses all lanes with fb_we=0.
- Reset mid-operation: the held request is discarded and no further writes are issued.
- s_data, s_mask and s_addr are ignored when not accepted.

Decomposition:
- Shared package vector_fb_pkg:
  - state enum {IDLE, WRITE}.
  - FB_PIXELS, FB_WIDTH=200 and LANES constants.
  - Lane-extract function for slicing a 256-bit vector.
- No sub-module required. Single module: FSM, lane counter, holding registers and saturating counter.

Test Plan:
- Basic store: s_addr=100, s_data lanes = 32'h0000_00i0+i, s_mask=8'hFF, fb_gnt=1 → fb_we on 8 consecutive cycles, fb_addr 100..107, correct lane data, s_ready high on the 8th cycle.
- Mask and back-to-back:
  - s_mask=8'b1010_0101, then a second request presented during the last lane → writes only at lanes 0,2,5,7.
  - Second request's lane 0 appears on the cycle directly after the first request's lane 7.
- Bounds: s_addr=39996, mask=8'hFF → writes at 39996..39999 only; oob_count=4.
- Address near 16'hFFFF: s_addr=16'hFFFC → no writes and no wrap to index 0; oob_count +8.
- Grant stall: fb_gnt low for 3 cycles at lane 3 → fb_we=0 and lane held; resumes at lane 3; s_ready stays 0 throughout.
- Reset during lane 4: assert reset → fb_we=0 immediately, busy=0, oob_count=0, s_ready=1; no write of lanes 5–7 after release.
